// File: rtl/rtc_core_cfg.sv
// rtc_core_cfg: BCD HH:MM:SS real-time clock with prescaler, 12/24 h display, validated loads and HH:MM alarm.
module rtc_core_cfg #(
   parameter int TICKS_PER_SEC = 1,
   parameter bit ALARM_EN      = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        mode_12h,
   input  logic        set_valid,
   input  logic [23:0] set_time,
   input  logic        alm_valid,
   input  logic [15:0] alm_time,
   input  logic        alm_arm,
   output logic [3:0]  HR_M,
   output logic [3:0]  HR_L,
   output logic [3:0]  MIN_M,
   output logic [3:0]  MIN_L,
   output logic [3:0]  SEC_M,
   output logic [3:0]  SEC_L,
   output logic        pm,
   output logic        sec_tick,
   output logic        day_wrap,
   output logic        alarm_hit,
   output logic        set_err
);
   localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);
   logic [PW-1:0] pc;
   logic [3:0] h_m, h_l, m_m, m_l, s_m, s_l;
   logic [3:0] n_h_m, n_h_l, n_m_m, n_m_l, n_s_m, n_s_l;
   logic [15:0] alm;
   logic c0, c1, c2, c3, wrap, tick, set_ok, alm_ok, hit;
   logic [4:0] hb, dh;
   function automatic logic hm_ok(input logic [15:0] t);
      return t[15:12] <= 4'd2 && t[11:8] <= (t[15:12] == 4'd2 ? 4'd3 : 4'd9) &&
             t[7:4] <= 4'd5 && t[3:0] <= 4'd9;
   endfunction
   assign tick   = en && pc == LAST;
   assign set_ok = set_valid && hm_ok(set_time[23:8]) && set_time[7:4] <= 4'd5 && set_time[3:0] <= 4'd9;
   assign alm_ok = alm_valid && hm_ok(alm_time);
   // Carry chain for the next second, each digit rolling only when all lower digits roll
   always_comb begin
      c0    = s_l == 4'd9;
      c1    = c0 && s_m == 4'd5;
      c2    = c1 && m_l == 4'd9;
      c3    = c2 && m_m == 4'd5;
      wrap  = c3 && h_m == 4'd2 && h_l == 4'd3;
      n_s_l = c0 ? 4'd0 : s_l + 4'd1;
      n_s_m = c1 ? 4'd0 : c0 ? s_m + 4'd1 : s_m;
      n_m_l = c2 ? 4'd0 : c1 ? m_l + 4'd1 : m_l;
      n_m_m = c3 ? 4'd0 : c2 ? m_m + 4'd1 : m_m;
      n_h_l = (wrap || (c3 && h_l == 4'd9)) ? 4'd0 : c3 ? h_l + 4'd1 : h_l;
      n_h_m = wrap ? 4'd0 : (c3 && h_l == 4'd9) ? h_m + 4'd1 : h_m;
      hit   = ALARM_EN && alm_arm && {n_h_m, n_h_l, n_m_m, n_m_l, n_s_m, n_s_l} == {alm, 8'h00};
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc <= '0;
         {h_m, h_l, m_m, m_l, s_m, s_l} <= '0;
         alm <= '0;
         sec_tick <= 1'b0;
         day_wrap <= 1'b0;
         alarm_hit <= 1'b0;
         set_err <= 1'b0;
      end else begin
         sec_tick <= !set_ok && tick;
         day_wrap <= !set_ok && tick && wrap;
         alarm_hit <= !set_ok && tick && hit;
         set_err <= (set_valid && !set_ok) || (alm_valid && !alm_ok);
         if (alm_ok) alm <= alm_time;
         if (set_ok) begin
            {h_m, h_l, m_m, m_l, s_m, s_l} <= set_time;
            pc <= '0;
         end else if (en) begin
            pc <= tick ? '0 : pc + PW'(1);
            if (tick) {h_m, h_l, m_m, m_l, s_m, s_l} <= {n_h_m, n_h_l, n_m_m, n_m_l, n_s_m, n_s_l};
         end
      end
   end
   // 12 h view is derived from the 24 h registers via a binary hour
   assign hb    = 5'(h_m) * 5'd10 + 5'(h_l);
   assign dh    = hb == 5'd0 ? 5'd12 : hb > 5'd12 ? hb - 5'd12 : hb;
   assign HR_M  = mode_12h ? (dh >= 5'd10 ? 4'd1 : 4'd0) : h_m;
   assign HR_L  = mode_12h ? 4'(dh >= 5'd10 ? dh - 5'd10 : dh) : h_l;
   assign pm    = mode_12h && hb >= 5'd12;
   assign MIN_M = m_m;
   assign MIN_L = m_l;
   assign SEC_M = s_m;
   assign SEC_L = s_l;
endmodule

// File: tb/tb_rtc_core_cfg.sv
// tb_rtc_core_cfg: directed vectors and corner sequences for rtc_core_cfg with TICKS_PER_SEC=4.
module tb_rtc_core_cfg;
   logic clk = 1'b0, reset = 1'b1, en = 1'b0, mode_12h = 1'b0;
   logic set_valid = 1'b0, alm_valid = 1'b0, alm_arm = 1'b0;
   logic [23:0] set_time = '0;
   logic [15:0] alm_time = '0;
   logic [3:0] HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L;
   logic pm, sec_tick, day_wrap, alarm_hit, set_err;
   logic [23:0] disp;
   int errs = 0, checks = 0;
   typedef struct {
      logic [23:0] t;
      logic        m;
      logic [23:0] d;
      logic        p;
      logic        e;
   } vec_t;
   vec_t tbl[11];
   rtc_core_cfg #(.TICKS_PER_SEC(4), .ALARM_EN(1)) dut (
      .clk(clk), .reset(reset), .en(en), .mode_12h(mode_12h),
      .set_valid(set_valid), .set_time(set_time), .alm_valid(alm_valid),
      .alm_time(alm_time), .alm_arm(alm_arm),
      .HR_M(HR_M), .HR_L(HR_L), .MIN_M(MIN_M), .MIN_L(MIN_L), .SEC_M(SEC_M), .SEC_L(SEC_L),
      .pm(pm), .sec_tick(sec_tick), .day_wrap(day_wrap), .alarm_hit(alarm_hit), .set_err(set_err)
   );
   assign disp = {HR_M, HR_L, MIN_M, MIN_L, SEC_M, SEC_L};
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic load(input logic [23:0] t);
      set_valid = 1'b1;
      set_time  = t;
      step();
      set_valid = 1'b0;
   endtask
   initial begin
      tbl[0]  = '{24'h130500, 1'b1, 24'h010500, 1'b1, 1'b0};
      tbl[1]  = '{24'h003000, 1'b1, 24'h123000, 1'b0, 1'b0};
      tbl[2]  = '{24'h120000, 1'b1, 24'h120000, 1'b1, 1'b0};
      tbl[3]  = '{24'h235959, 1'b1, 24'h115959, 1'b1, 1'b0};
      tbl[4]  = '{24'h110000, 1'b1, 24'h110000, 1'b0, 1'b0};
      tbl[5]  = '{24'h130500, 1'b0, 24'h130500, 1'b0, 1'b0};
      tbl[6]  = '{24'h245959, 1'b0, 24'h130500, 1'b0, 1'b1};
      tbl[7]  = '{24'h0A0000, 1'b1, 24'h010500, 1'b1, 1'b1};
      tbl[8]  = '{24'h00006A, 1'b0, 24'h130500, 1'b0, 1'b1};
      tbl[9]  = '{24'h195900, 1'b1, 24'h075900, 1'b1, 1'b0};
      tbl[10] = '{24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0};
      step();
      step();
      chk("rst_disp", 32'(disp), 0);
      chk("rst_tick", 32'(sec_tick), 0);
      chk("rst_wrap", 32'(day_wrap), 0);
      chk("rst_alarm", 32'(alarm_hit), 0);
      chk("rst_err", 32'(set_err), 0);
      mode_12h = 1'b1;
      #1;
      chk("rst_disp12", 32'(disp), 32'h120000);
      chk("rst_pm12", 32'(pm), 0);
      mode_12h = 1'b0;
      en = 1'b1;
      reset = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         step();
         chk("run_tick", 32'(sec_tick), 32'(i % 4 == 0));
      end
      chk("run_10s", 32'(disp), 32'h000010);
      load(24'h235958);
      chk("wrap_load", 32'(disp), 32'h235958);
      chk("wrap_load_tick", 32'(sec_tick), 0);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("wrap_tick", 32'(sec_tick), 32'(i % 4 == 0));
         chk("wrap_pulse", 32'(day_wrap), 32'(i == 8));
         if (i == 4) chk("wrap_59", 32'(disp), 32'h235959);
      end
      chk("wrap_00", 32'(disp), 32'h000000);
      load(24'h240000);
      chk("bad_err1", 32'(set_err), 1);
      chk("bad_disp1", 32'(disp), 32'h000000);
      step();
      chk("bad_err1_off", 32'(set_err), 0);
      load(24'h126000);
      chk("bad_err2", 32'(set_err), 1);
      chk("bad_disp2", 32'(disp), 32'h000000);
      step();
      chk("bad_count_on", 32'(disp), 32'h000001);
      chk("bad_count_tick", 32'(sec_tick), 1);
      chk("bad_err2_off", 32'(set_err), 0);
      step();
      step();
      step();
      load(24'h000000);
      chk("supp_tick", 32'(sec_tick), 0);
      chk("supp_disp", 32'(disp), 32'h000000);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("supp_after", 32'(sec_tick), 32'(i == 4));
      end
      chk("supp_disp2", 32'(disp), 32'h000001);
      en = 1'b0;
      foreach (tbl[k]) begin
         mode_12h = tbl[k].m;
         load(tbl[k].t);
         chk($sformatf("vec%0d_disp", k), 32'(disp), 32'(tbl[k].d));
         chk($sformatf("vec%0d_pm", k), 32'(pm), 32'(tbl[k].p));
         chk($sformatf("vec%0d_err", k), 32'(set_err), 32'(tbl[k].e));
      end
      mode_12h = 1'b0;
      en = 1'b1;
      alm_arm = 1'b1;
      alm_valid = 1'b1;
      alm_time = 16'h0700;
      load(24'h065958);
      alm_valid = 1'b0;
      chk("alm_load_err", 32'(set_err), 0);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("alm_hit", 32'(alarm_hit), 32'(i == 8));
      end
      chk("alm_disp", 32'(disp), 32'h070000);
      alm_valid = 1'b1;
      alm_time = 16'h0760;
      step();
      alm_valid = 1'b0;
      chk("alm_bad_err", 32'(set_err), 1);
      alm_arm = 1'b0;
      load(24'h065958);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("alm_disarm", 32'(alarm_hit), 0);
      end
      alm_arm = 1'b1;
      load(24'h065958);
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("alm_kept", 32'(alarm_hit), 32'(i == 8));
      end
      load(24'h070000);
      chk("alm_load_nohit", 32'(alarm_hit), 0);
      alm_valid = 1'b1;
      alm_time = 16'h2400;
      load(24'h120000);
      alm_valid = 1'b0;
      chk("dual_err", 32'(set_err), 1);
      chk("dual_disp", 32'(disp), 32'h120000);
      load(24'h000000);
      for (int i = 1; i <= 7; i++) begin
         en = !(i >= 3 && i <= 5);
         step();
         chk("en_stretch", 32'(sec_tick), 32'(i == 7));
      end
      en = 1'b1;
      step();
      step();
      chk("pre_rst_disp", 32'(disp), 32'h000001);
      reset = 1'b1;
      #1;
      chk("async_rst_disp", 32'(disp), 0);
      chk("async_rst_err", 32'(set_err), 0);
      step();
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("post_rst_tick", 32'(sec_tick), 32'(i == 4));
      end
      chk("post_rst_disp", 32'(disp), 32'h000001);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
